// File: rtl/pll_ctrl_pkg.sv
// Shared types and the PLL profile table for the PLL reconfiguration controller.
// Divider port codes are raw values: each 6-bit field carries (64 - divide ratio).
package pll_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_RST_ASSERT = 3'd0,
        ST_WAIT_LOCK  = 3'd1,
        ST_STABLE_CHK = 3'd2,
        ST_RUN        = 3'd3,
        ST_FAIL       = 3'd4
    } pll_state_e;

    typedef struct packed {
        logic [5:0] idsel;
        logic [5:0] fbdsel;
        logic [5:0] odsel;
    } pll_prof_t;

    function automatic logic [5:0] div_code(input int unsigned ratio);
        return 6'(64 - ratio);
    endfunction

    // 27 MHz reference: 0 -> x8/3 = 72 MHz (VCO 576), 1 -> x4 = 108 MHz (VCO 432),
    // 2 -> x10/3 = 90 MHz (VCO 540), 3 -> x2 = 54 MHz (VCO 432)
    function automatic pll_prof_t prof_lookup(input logic [1:0] sel);
        pll_prof_t p;
        case (sel)
            2'd0:    p = '{idsel: div_code(3), fbdsel: div_code(8),  odsel: div_code(8)};
            2'd1:    p = '{idsel: div_code(1), fbdsel: div_code(4),  odsel: div_code(4)};
            2'd2:    p = '{idsel: div_code(3), fbdsel: div_code(10), odsel: div_code(6)};
            default: p = '{idsel: div_code(1), fbdsel: div_code(2),  odsel: div_code(8)};
        endcase
        return p;
    endfunction

endpackage

// File: rtl/pll_lock_sync.sv
// Two-flop synchroniser for the raw PLL lock plus a saturating counter of
// consecutive synchronised-high cycles.
module pll_lock_sync #(
    parameter int unsigned LOCK_STABLE = 1024
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic lock_i,
    input  logic cnt_en_i,
    output logic lock_o,
    output logic stable_o
);

    localparam int unsigned SW = $clog2(LOCK_STABLE) + 1;

    logic          s1_q, s2_q;
    logic [SW-1:0] cnt_q, cnt_d;

    // Synchroniser flops and stability counter register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_q  <= 1'b0;
            s2_q  <= 1'b0;
            cnt_q <= '0;
        end else begin
            s1_q  <= lock_i;
            s2_q  <= s1_q;
            cnt_q <= cnt_d;
        end
    end

    // Restart on any low synchronised cycle, saturate at LOCK_STABLE
    always_comb begin
        cnt_d = cnt_q;
        if (!cnt_en_i || !s2_q) begin
            cnt_d = '0;
        end else if (cnt_q != SW'(LOCK_STABLE)) begin
            cnt_d = cnt_q + SW'(1);
        end
    end

    assign lock_o   = s2_q;
    assign stable_o = (cnt_q == SW'(LOCK_STABLE));

endmodule

// File: rtl/pll_reconfig_ctrl.sv
// PLL reconfiguration controller: applies one of four divider profiles,
// sequences PLL reset, waits for a stable lock with timeout/retry, and
// reports completion of accepted profile-change requests.
module pll_reconfig_ctrl
    import pll_ctrl_pkg::*;
#(
    parameter int unsigned RESET_CYCLES = 16,
    parameter int unsigned LOCK_STABLE  = 1024,
    parameter int unsigned LOCK_TIMEOUT = 65535,
    parameter int unsigned MAX_RETRY    = 3
) (
    input  logic       clkin,
    input  logic       reset_n,
    input  logic       req,
    input  logic [1:0] sel,
    output logic       ack,
    output logic       busy,
    output logic       error,
    output logic [1:0] cur_sel,
    input  logic       pll_lock,
    output logic       pll_reset,
    output logic [5:0] pll_idsel,
    output logic [5:0] pll_fbdsel,
    output logic [5:0] pll_odsel,
    output logic       locked,
    output logic       rst_out_n
);

    localparam int unsigned RW = $clog2(RESET_CYCLES) + 1;
    localparam int unsigned TW = $clog2(LOCK_TIMEOUT) + 1;
    localparam int unsigned YW = $clog2(MAX_RETRY) + 1;

    pll_state_e    state_q, state_d;
    logic [RW-1:0] rst_cnt_q, rst_cnt_d;
    logic [TW-1:0] to_cnt_q, to_cnt_d, to_inc;
    logic [YW-1:0] retry_q, retry_d, retry_inc;
    logic [1:0]    sel_q, sel_d;
    pll_prof_t     prof_q, prof_d;
    logic          pend_q, pend_d;
    logic          ack_q, ack_d;
    logic          lock_s, stable_s;

    pll_lock_sync #(
        .LOCK_STABLE(LOCK_STABLE)
    ) u_lock_sync (
        .clk_i   (clkin),
        .rst_ni  (reset_n),
        .lock_i  (pll_lock),
        .cnt_en_i((state_q == ST_WAIT_LOCK) || (state_q == ST_STABLE_CHK)),
        .lock_o  (lock_s),
        .stable_o(stable_s)
    );

    // State, counters, applied profile and ack bookkeeping
    always_ff @(posedge clkin or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_RST_ASSERT;
            rst_cnt_q <= '0;
            to_cnt_q  <= '0;
            retry_q   <= '0;
            sel_q     <= 2'd0;
            prof_q    <= prof_lookup(2'd0);
            pend_q    <= 1'b0;
            ack_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            rst_cnt_q <= rst_cnt_d;
            to_cnt_q  <= to_cnt_d;
            retry_q   <= retry_d;
            sel_q     <= sel_d;
            prof_q    <= prof_d;
            pend_q    <= pend_d;
            ack_q     <= ack_d;
        end
    end

    // Next-state: reset sequencing, lock wait with timeout/retry, request intake
    always_comb begin
        state_d   = state_q;
        rst_cnt_d = '0;
        to_cnt_d  = '0;
        retry_d   = retry_q;
        sel_d     = sel_q;
        prof_d    = prof_q;
        pend_d    = pend_q;
        ack_d     = 1'b0;
        to_inc    = (to_cnt_q == TW'(LOCK_TIMEOUT)) ? to_cnt_q : to_cnt_q + TW'(1);
        retry_inc = (retry_q == YW'(MAX_RETRY)) ? retry_q : retry_q + YW'(1);

        case (state_q)
            ST_RST_ASSERT: begin
                if (rst_cnt_q == RW'(RESET_CYCLES - 1)) begin
                    state_d = ST_WAIT_LOCK;
                end else begin
                    rst_cnt_d = rst_cnt_q + RW'(1);
                end
            end
            ST_WAIT_LOCK: begin
                if (lock_s) begin
                    state_d = ST_STABLE_CHK;
                end else if (to_inc == TW'(LOCK_TIMEOUT)) begin
                    retry_d = retry_inc;
                    state_d = (retry_inc < YW'(MAX_RETRY)) ? ST_RST_ASSERT : ST_FAIL;
                end else begin
                    to_cnt_d = to_inc;
                end
            end
            ST_STABLE_CHK: begin
                if (stable_s) begin
                    state_d = ST_RUN;
                    retry_d = '0;
                end
            end
            ST_RUN, ST_FAIL: begin
                if (req) begin
                    state_d = ST_RST_ASSERT;
                    sel_d   = sel;
                    prof_d  = prof_lookup(sel);
                    pend_d  = 1'b1;
                    retry_d = '0;
                end else if (state_q == ST_RUN && !lock_s) begin
                    state_d = ST_RST_ASSERT;
                    retry_d = '0;
                end
            end
            default: state_d = ST_RST_ASSERT;
        endcase

        // ack only closes out an accepted request; relocks leave pend_q clear
        if ((state_d == ST_RUN || state_d == ST_FAIL) && state_d != state_q) begin
            ack_d  = pend_q;
            pend_d = 1'b0;
        end
    end

    // Outputs decoded from registered state
    always_comb begin
        pll_reset  = (state_q == ST_RST_ASSERT) || (state_q == ST_FAIL);
        busy       = (state_q != ST_RUN) && (state_q != ST_FAIL);
        error      = (state_q == ST_FAIL);
        locked     = (state_q == ST_RUN) && lock_s;
        rst_out_n  = locked;
        ack        = ack_q;
        cur_sel    = sel_q;
        pll_idsel  = prof_q.idsel;
        pll_fbdsel = prof_q.fbdsel;
        pll_odsel  = prof_q.odsel;
    end

endmodule
